// File: rtl/button_debouncer.sv
// button_debouncer
//   Synchronises and debounces five raw controller buttons. It emits one-cycle
//   press/release edge pulses for the player FSM.
//   Within each half the bits are: 0 = up, 1 = down, 2 = left, 3 = right,
//   4 = attack.
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   raw_buttons[4:0]    raw active-high buttons (async to clk, may bounce)
//   input_data[9:0]     [9:5] press pulses, [4:0] release pulses, one clk wide
//   buttons_stable[4:0] debounced button levels
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] raw_buttons,
  output logic [9:0] input_data,
  output logic [4:0] buttons_stable
);

  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       r_s1;
  logic [4:0]       r_s2;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       r_stable;
  logic [9:0]       r_data;

  logic [4:0]       w_differ;
  logic [4:0]       w_accept;
  logic [4:0]       w_press;
  logic [4:0]       w_release;

  // A bit is accepted on the cycle that completes DEBOUNCE_CYCLES consecutive
  // disagreements. The pulse and the new stable level land on the same edge.
  always_comb begin
    w_differ  = r_s2 ^ r_stable;
    w_accept  = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      w_accept[i] = w_differ[i] && (r_cnt[i] == LP_TERM);
    end
    w_press   = w_accept & r_s2;
    w_release = w_accept & ~r_s2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_buttons;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (!w_differ[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      r_data   <= '0;
    end else begin
      r_stable <= (r_stable & ~w_accept) | (r_s2 & w_accept);
      r_data   <= {w_press, w_release};
    end
  end

  assign input_data     = r_data;
  assign buttons_stable = r_stable;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] raw_buttons = '0;
  logic [9:0] input_data;
  logic [4:0] buttons_stable;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .raw_buttons(raw_buttons),
    .input_data(input_data),
    .buttons_stable(buttons_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the synced level seen before edge k is the raw value sampled at
  // edge k-2 since reset. A button flips when the last D synced levels all
  // disagree with its stable level.
  logic [4:0] raw_hist [$];
  logic [4:0] s2w [$];
  logic [4:0] m_stable = '0;
  logic [9:0] m_data = '0;
  logic [4:0] m_s2p;
  logic [4:0] m_next;
  logic       m_all;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_hist.delete();
      s2w.delete();
      m_stable = '0;
      m_data   = '0;
    end else begin
      m_s2p = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'h00;
      s2w.push_back(m_s2p);
      raw_hist.push_back(raw_buttons);
      if (raw_hist.size() > 8) void'(raw_hist.pop_front());
      if (s2w.size() > D) void'(s2w.pop_front());
      m_data = '0;
      m_next = m_stable;
      for (int b = 0; b < 5; b++) begin
        if (s2w.size() == D) begin
          m_all = 1'b1;
          for (int j = 0; j < D; j++) if (s2w[j][b] == m_stable[b]) m_all = 1'b0;
          if (m_all) begin
            m_next[b] = ~m_stable[b];
            if (m_next[b]) m_data[5+b] = 1'b1;
            else m_data[b] = 1'b1;
          end
        end
      end
      m_stable = m_next;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_data", input_data, m_data);
      chk("cyc_stable", {5'b0, buttons_stable}, {5'b0, m_stable});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v);
    @(negedge clk);
    raw_buttons = v;
  endtask

  initial begin
    // Reset with all buttons held
    @(negedge clk);
    raw_buttons = 5'h1F;
    #2 reset = 1'b1;
    #1;
    chk("rst_data", input_data, 10'h000);
    chk("rst_stable", {5'b0, buttons_stable}, 10'h000);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    edges(5);
    chk("rst_e4_data", input_data, 10'h000);
    edges(1);
    chk("rst_e5_stable", {5'b0, buttons_stable}, 10'h01F);
    chk("rst_e5_data", input_data, 10'h3E0);
    edges(1);
    chk("rst_e6_data", input_data, 10'h000);
    drive(5'h00);
    edges(10);
    chk("rel_all_stable", {5'b0, buttons_stable}, 10'h000);

    // Clean press and release of up
    drive(5'h01);
    edges(5);
    chk("press_e4_data", input_data, 10'h000);
    edges(1);
    chk("press_e5_data", input_data, 10'h020);
    chk("press_e5_stable", {5'b0, buttons_stable}, 10'h001);
    edges(1);
    chk("press_e6_data", input_data, 10'h000);
    edges(3);
    drive(5'h00);
    edges(6);
    chk("release_e5_data", input_data, 10'h001);
    edges(1);
    chk("release_e6_data", input_data, 10'h000);
    edges(4);

    // Bouncing attack button
    drive(5'h10);
    drive(5'h00);
    drive(5'h10);
    drive(5'h00);
    drive(5'h10);
    edges(5);
    chk("bounce_e4_data", input_data, 10'h000);
    edges(1);
    chk("bounce_e5_data", input_data, 10'h200);
    drive(5'h00);
    edges(10);

    // Glitch of D-1 cycles on left
    drive(5'h04);
    edges(3);
    drive(5'h00);
    edges(10);
    chk("glitch_stable", {5'b0, buttons_stable}, 10'h000);

    // Simultaneous press of right and release of down
    drive(5'h02);
    edges(10);
    chk("pre_sim_stable", {5'b0, buttons_stable}, 10'h002);
    drive(5'h08);
    edges(6);
    chk("sim_e5_data", input_data, 10'h102);
    drive(5'h00);
    edges(10);

    // Reset mid-count on down
    drive(5'h02);
    edges(3);
    chk("midrst_pre_data", input_data, 10'h000);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    edges(5);
    chk("midrst_e4_data", input_data, 10'h000);
    edges(1);
    chk("midrst_e5_data", input_data, 10'h040);
    edges(3);

    // Reset clears a held stable level immediately
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_hold_stable", {5'b0, buttons_stable}, 10'h000);
    @(negedge clk);
    reset = 1'b0;
    drive(5'h00);
    edges(12);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
